core_mem_arbiter: RTL and testbench

Shares the core's single word-addressed memory bus between the instruction fetch port and the load/store data port. Each requester issues one-cycle start pulses with a ready pulse back, and may issue back-to-back multi-register transfers. The arbiter latches requests, grants the bus to one requester at a time, drives an Avalon-style master and returns read data. It sits between the core control/fetch logic and the external bus interconnect.

---
 rtl/core_mem_arbiter_if.sv | 51 +++++
 rtl/core_mem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_core_mem_arbiter.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_mem_arbiter_if.sv
// core_mem_arbiter_if
// Bundles the memory-arbiter signals: the fetch port, the load/store data port
// and the Avalon-style master bus.
//   slave  modport : the arbiter's view (takes starts and bus read data,
//                    drives readies, read data and the bus command).
//   master modport : the environment's view (requesters plus bus interconnect).
// Signals:
//   insn_start/insn_addr            fetch request pulse and word address
//   insn_ready/insn_data            fetch completion pulse and fetched word
//   data_start/data_write/data_addr/data_wr  load/store request
//   data_ready/data_rd              load/store completion pulse and load data
//   avl_address/avl_read/avl_write/avl_writedata  bus command
//   avl_readdata/avl_waitrequest    bus response and stall
interface core_mem_arbiter_if;
    logic        insn_start;
    logic [29:0] insn_addr;
    logic        insn_ready;
    logic [31:0] insn_data;

    logic        data_start;
    logic        data_write;
    logic [29:0] data_addr;
    logic [31:0] data_wr;
    logic        data_ready;
    logic [31:0] data_rd;

    logic [31:0] avl_address;
    logic        avl_read;
    logic        avl_write;
    logic [31:0] avl_writedata;
    logic [31:0] avl_readdata;
    logic        avl_waitrequest;

    modport slave (
        input  insn_start, insn_addr,
        input  data_start, data_write, data_addr, data_wr,
        input  avl_readdata, avl_waitrequest,
        output insn_ready, insn_data,
        output data_ready, data_rd,
        output avl_address, avl_read, avl_write, avl_writedata
    );

    modport master (
        output insn_start, insn_addr,
        output data_start, data_write, data_addr, data_wr,
        output avl_readdata, avl_waitrequest,
        input  insn_ready, insn_data,
        input  data_ready, data_rd,
        input  avl_address, avl_read, avl_write, avl_writedata
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// core_mem_arbiter
// Shares one word-addressed Avalon-style memory bus between the instruction
// fetch port and the load/store data port. Each port has a one-entry request
// latch; the arbiter grants one request at a time, holds the bus command until
// waitrequest drops, and returns a one-cycle ready pulse the cycle after.
// Ports:
//   clk  core clock
//   rst  asynchronous active-high reset
//   bus  core_mem_arbiter_if.slave (fetch port, data port, Avalon master)
// Configuration macro:
//   CORE_MEM_ARB_ROUND_ROBIN_EN  when defined, ties between both ports go to
//   the port not granted last (data wins the first tie); otherwise data
//   always beats fetch.
module core_mem_arbiter (
    input  logic              clk,
    input  logic              rst,
    core_mem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_BUS_INSN = 2'd1,
        ST_BUS_DATA = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    // Request latches
    logic        r_insn_pend;
    logic [29:0] r_insn_addr;
    logic        r_data_pend;
    logic        r_data_write;
    logic [29:0] r_data_addr;
    logic [31:0] r_data_wdata;

    // Registered outputs
    logic [31:0] r_avl_address;
    logic        r_avl_read;
    logic        r_avl_write;
    logic [31:0] r_avl_writedata;
    logic        r_insn_ready;
    logic [31:0] r_insn_data;
    logic        r_data_ready;
    logic [31:0] r_data_rd;

    logic        w_busy;
    logic        w_cmd_done;
    logic        w_grant_pt;
    logic        w_insn_accept;
    logic        w_data_accept;
    logic        w_insn_req;
    logic        w_data_req;
    logic [29:0] w_insn_addr;
    logic        w_data_write;
    logic [29:0] w_data_addr;
    logic [31:0] w_data_wdata;
    logic        w_data_prio;
    logic        w_grant_data;
    logic        w_grant_insn;

    // A start is taken only when that port has nothing pending or on the bus;
    // otherwise it is a protocol violation and the original request stands.
    assign w_insn_accept = bus.insn_start & ~r_insn_pend & (r_state != ST_BUS_INSN);
    assign w_data_accept = bus.data_start & ~r_data_pend & (r_state != ST_BUS_DATA);

    // Requests arriving in the grant cycle compete alongside latched ones, so
    // the effective request fields bypass the latch when it is empty.
    assign w_insn_req   = r_insn_pend | w_insn_accept;
    assign w_data_req   = r_data_pend | w_data_accept;
    assign w_insn_addr  = r_insn_pend ? r_insn_addr  : bus.insn_addr;
    assign w_data_write = r_data_pend ? r_data_write : bus.data_write;
    assign w_data_addr  = r_data_pend ? r_data_addr  : bus.data_addr;
    assign w_data_wdata = r_data_pend ? r_data_wdata : bus.data_wr;

`ifdef CORE_MEM_ARB_ROUND_ROBIN_EN
    logic r_last_data;  // 1 = data port was granted last

    // Tracks which port won the most recent grant for tie-breaking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_data <= 1'b0;
        end else if (w_grant_data) begin
            r_last_data <= 1'b1;
        end else if (w_grant_insn) begin
            r_last_data <= 1'b0;
        end
    end

    assign w_data_prio = ~r_last_data;
`else
    assign w_data_prio = 1'b1;
`endif

    assign w_cmd_done   = w_busy & ~bus.avl_waitrequest;
    assign w_grant_pt   = (r_state == ST_IDLE) | w_cmd_done;
    assign w_grant_data = w_grant_pt & w_data_req & (~w_insn_req | w_data_prio);
    assign w_grant_insn = w_grant_pt & w_insn_req & ~w_grant_data;

    // Decodes whether a bus command is outstanding in the current state
    always_comb begin
        w_busy = 1'b0;
        case (r_state)
            ST_IDLE:     w_busy = 1'b0;
            ST_BUS_INSN: w_busy = 1'b1;
            ST_BUS_DATA: w_busy = 1'b1;
            default:     w_busy = 1'b0;
        endcase
    end

    // Next-state: the state only moves at a grant point
    always_comb begin
        w_state_nxt = r_state;
        if (w_grant_pt) begin
            if (w_grant_data) begin
                w_state_nxt = ST_BUS_DATA;
            end else if (w_grant_insn) begin
                w_state_nxt = ST_BUS_INSN;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end else begin
            w_state_nxt = r_state;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request latches: capture on accept, clear when granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_insn_pend  <= 1'b0;
            r_insn_addr  <= 30'd0;
            r_data_pend  <= 1'b0;
            r_data_write <= 1'b0;
            r_data_addr  <= 30'd0;
            r_data_wdata <= 32'd0;
        end else begin
            if (w_insn_accept) begin
                r_insn_addr <= bus.insn_addr;
            end
            if (w_grant_insn) begin
                r_insn_pend <= 1'b0;
            end else if (w_insn_accept) begin
                r_insn_pend <= 1'b1;
            end

            if (w_data_accept) begin
                r_data_write <= bus.data_write;
                r_data_addr  <= bus.data_addr;
                r_data_wdata <= bus.data_wr;
            end
            if (w_grant_data) begin
                r_data_pend <= 1'b0;
            end else if (w_data_accept) begin
                r_data_pend <= 1'b1;
            end
        end
    end

    // Bus command: loaded at a grant point, otherwise held unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_avl_address   <= 32'd0;
            r_avl_read      <= 1'b0;
            r_avl_write     <= 1'b0;
            r_avl_writedata <= 32'd0;
        end else if (w_grant_data) begin
            r_avl_address   <= {w_data_addr, 2'b00};
            r_avl_read      <= ~w_data_write;
            r_avl_write     <= w_data_write;
            r_avl_writedata <= w_data_wdata;
        end else if (w_grant_insn) begin
            r_avl_address   <= {w_insn_addr, 2'b00};
            r_avl_read      <= 1'b1;
            r_avl_write     <= 1'b0;
        end else if (w_grant_pt) begin
            r_avl_read      <= 1'b0;
            r_avl_write     <= 1'b0;
        end
    end

    // Completion: ready pulse next cycle; read data captured, stores leave data_rd
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_insn_ready <= 1'b0;
            r_insn_data  <= 32'd0;
            r_data_ready <= 1'b0;
            r_data_rd    <= 32'd0;
        end else begin
            r_insn_ready <= w_cmd_done & (r_state == ST_BUS_INSN);
            r_data_ready <= w_cmd_done & (r_state == ST_BUS_DATA);
            if (w_cmd_done && (r_state == ST_BUS_INSN)) begin
                r_insn_data <= bus.avl_readdata;
            end
            if (w_cmd_done && (r_state == ST_BUS_DATA) && !r_avl_write) begin
                r_data_rd <= bus.avl_readdata;
            end
        end
    end

    assign bus.avl_address   = r_avl_address;
    assign bus.avl_read      = r_avl_read;
    assign bus.avl_write     = r_avl_write;
    assign bus.avl_writedata = r_avl_writedata;
    assign bus.insn_ready    = r_insn_ready;
    assign bus.insn_data     = r_insn_data;
    assign bus.data_ready    = r_data_ready;
    assign bus.data_rd       = r_data_rd;

endmodule

// File: tb/tb_core_mem_arbiter.sv
// Bench for core_mem_arbiter: directed scenarios plus randomized traffic.
// A reference model (per-port request sets, one in-flight command, the
// arbitration rule) predicts each bus command and each ready pulse; a negedge
// monitor compares the DUT against it through an expected-response queue.
module tb_core_mem_arbiter;

    logic clk;
    logic rst;

    core_mem_arbiter_if bus_if ();

    core_mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vec  = 0;
    int miss = 0;
    int viol = 0;
    int cyc  = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vec++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Bus slave read data: a fixed word at 0x400, a hash of the address elsewhere
    function automatic logic [31:0] rd_val(input logic [31:0] a);
        if (a == 32'h0000_0400) return 32'hE3A0_0001;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        int          due;
        logic [31:0] d;
    } exp_t;

    exp_t        qi[$];
    exp_t        qd[$];
    logic [1:0]  m_pv;
    logic [29:0] m_pa [2];
    logic        m_pw [2];
    logic [31:0] m_pd [2];
    logic        m_fv;
    int          m_fp;
    logic [29:0] m_fa;
    logic        m_fw;
    logic [31:0] m_fd;
    int          m_last;
    logic [31:0] m_drd;
    int          win;
    logic        busy_i;
    logic        busy_d;
    logic [31:0] rv;

    // Winner among pending requests when the bus is free
    function automatic int pick(input logic [1:0] pv, input int last);
`ifdef CORE_MEM_ARB_ROUND_ROBIN_EN
        if (pv == 2'b11) return (last == 0) ? 1 : 0;
`endif
        return pv[1] ? 1 : 0;
    endfunction

    // Monitor: one model step per cycle, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            m_pv   = 2'b00;
            m_fv   = 1'b0;
            m_last = 0;
            m_drd  = 32'd0;
            qi.delete();
            qd.delete();
        end else begin
            // ready pulses
            if (qi.size() > 0 && qi[0].due == cyc) begin
                chk("insn_ready", 64'(bus_if.insn_ready), 64'(1));
                chk("insn_data", 64'(bus_if.insn_data), 64'(qi[0].d));
                void'(qi.pop_front());
            end else begin
                chk("insn_ready_quiet", 64'(bus_if.insn_ready), 64'(0));
            end
            if (qd.size() > 0 && qd[0].due == cyc) begin
                chk("data_ready", 64'(bus_if.data_ready), 64'(1));
                chk("data_rd", 64'(bus_if.data_rd), 64'(qd[0].d));
                void'(qd.pop_front());
            end else begin
                chk("data_ready_quiet", 64'(bus_if.data_ready), 64'(0));
            end

            // bus command: a free bus with anything pending must carry the winner now
            if (!m_fv && m_pv != 2'b00) begin
                win     = pick(m_pv, m_last);
                m_fv    = 1'b1;
                m_fp    = win;
                m_fa    = m_pa[win];
                m_fw    = m_pw[win];
                m_fd    = m_pd[win];
                m_pv[win] = 1'b0;
                m_last  = win;
            end
            if (m_fv) begin
                chk("bus_cmd", 64'({bus_if.avl_read, bus_if.avl_write, bus_if.avl_address}),
                    64'({~m_fw, m_fw, m_fa, 2'b00}));
                if (m_fw) chk("bus_wdata", 64'(bus_if.avl_writedata), 64'(m_fd));
            end else begin
                chk("bus_idle", 64'({bus_if.avl_read, bus_if.avl_write}), 64'(0));
            end

            busy_i = m_pv[0] || (m_fv && m_fp == 0);
            busy_d = m_pv[1] || (m_fv && m_fp == 1);

            // completion
            if (m_fv && !bus_if.avl_waitrequest) begin
                rv = rd_val({m_fa, 2'b00});
                if (m_fp == 0) begin
                    qi.push_back('{cyc + 1, rv});
                end else begin
                    if (!m_fw) m_drd = rv;
                    qd.push_back('{cyc + 1, m_drd});
                end
                m_fv = 1'b0;
            end

            // new requests
            if (bus_if.insn_start) begin
                if (busy_i) viol++;
                else begin
                    m_pv[0] = 1'b1; m_pa[0] = bus_if.insn_addr; m_pw[0] = 1'b0; m_pd[0] = 32'd0;
                end
            end
            if (bus_if.data_start) begin
                if (busy_d) viol++;
                else begin
                    m_pv[1] = 1'b1; m_pa[1] = bus_if.data_addr;
                    m_pw[1] = bus_if.data_write; m_pd[1] = bus_if.data_wr;
                end
            end
        end
        cyc++;
    end

    // ---------------- stimulus ----------------
    task automatic drv(input logic is, input logic [29:0] ia, input logic ds, input logic dw,
                       input logic [29:0] da, input logic [31:0] dwd, input logic wr);
        bus_if.insn_start      = is;
        bus_if.insn_addr       = ia;
        bus_if.data_start      = ds;
        bus_if.data_write      = dw;
        bus_if.data_addr       = da;
        bus_if.data_wr         = dwd;
        bus_if.avl_waitrequest = wr;
        bus_if.avl_readdata    = rd_val(bus_if.avl_address);
        @(posedge clk);
        #1;
        bus_if.insn_start = 1'b0;
        bus_if.data_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, 64'({bus_if.avl_read, bus_if.avl_write, bus_if.insn_ready, bus_if.data_ready}), 64'(0));
        chk(name, 64'(bus_if.avl_address), 64'(0));
        chk(name, 64'(bus_if.avl_writedata), 64'(0));
        chk(name, 64'(bus_if.insn_data), 64'(0));
        chk(name, 64'(bus_if.data_rd), 64'(0));
    endtask

    int n;
    int v0;

    initial begin
        rst = 1'b1;
        bus_if.insn_start = 1'b0; bus_if.insn_addr = 30'd0;
        bus_if.data_start = 1'b0; bus_if.data_write = 1'b0;
        bus_if.data_addr = 30'd0; bus_if.data_wr = 32'd0;
        bus_if.avl_readdata = 32'd0; bus_if.avl_waitrequest = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset_value");
        rst = 1'b0;

        // single fetch, no stall
        drv(1'b1, 30'h100, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
        chk("fetch_cmd", 64'({bus_if.avl_read, bus_if.avl_write, bus_if.avl_address}), 64'({2'b10, 32'h0000_0400}));
        drv(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
        chk("fetch_ready", 64'(bus_if.insn_ready), 64'(1));
        chk("fetch_data", 64'(bus_if.insn_data), 64'(32'hE3A0_0001));
        idle(2);

        // store held through three stall cycles
        drv(1'b0, 30'd0, 1'b1, 1'b1, 30'h10, 32'hDEAD_BEEF, 1'b0);
        for (int k = 0; k < 4; k++) begin
            chk("store_hold", 64'({bus_if.avl_read, bus_if.avl_write, bus_if.avl_address}), 64'({2'b01, 32'h0000_0040}));
            chk("store_wdata", 64'(bus_if.avl_writedata), 64'(32'hDEAD_BEEF));
            drv(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, (k < 3) ? 1'b1 : 1'b0);
        end
        chk("store_ready", 64'(bus_if.data_ready), 64'(1));
        chk("store_rd_keep", 64'(bus_if.data_rd), 64'(0));
        idle(2);

        // simultaneous starts: data first, fetch on the bus with data_ready
        drv(1'b1, 30'h20, 1'b1, 1'b0, 30'h30, 32'd0, 1'b0);
        chk("coll_first", 64'({bus_if.avl_read, bus_if.avl_address}), 64'({1'b1, 32'h0000_00C0}));
        drv(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
        chk("coll_dready", 64'(bus_if.data_ready), 64'(1));
        chk("coll_drd", 64'(bus_if.data_rd), 64'(rd_val(32'h0000_00C0)));
        chk("coll_second", 64'({bus_if.avl_read, bus_if.avl_address}), 64'({1'b1, 32'h0000_0080}));
        drv(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b0);
        chk("coll_iready", 64'(bus_if.insn_ready), 64'(1));
        idle(2);

        // four chained loads with a fetch pending
        drv(1'b1, 30'h40, 1'b1, 1'b0, 30'h50, 32'd0, 1'b0);
        n = 1;
        for (int t = 0; t < 40 && n < 4; t++) begin
            if (bus_if.data_ready) begin
                drv(1'b0, 30'd0, 1'b1, 1'b0, 30'h50 + 30'(n), 32'd0, 1'b0);
                n++;
            end else begin
                idle(1);
            end
        end
        chk("chain_count", 64'(n), 64'(4));
        idle(6);

        // reset during a stalled read
        drv(1'b1, 30'h123, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1);
        drv(1'b0, 30'd0, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1);
        chk("rst_pre_read", 64'(bus_if.avl_read), 64'(1));
        #1;
        rst = 1'b1;
        #1;
        chk_all_zero("rst_async");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(4);
        drv(1'b0, 30'd0, 1'b1, 1'b0, 30'h7, 32'd0, 1'b0);
        chk("rst_idle_lat", 64'({bus_if.avl_read, bus_if.avl_address}), 64'({1'b1, 32'h0000_001C}));
        idle(3);

        // duplicate fetch start while the first is stalled
        v0 = viol;
        drv(1'b1, 30'h200, 1'b0, 1'b0, 30'd0, 32'd0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("dup_addr", 64'(bus_if.avl_address), 64'(32'h0000_0800));
            drv((k == 0) ? 1'b1 : 1'b0, 30'h300, 1'b0, 1'b0, 30'd0, 32'd0, (k < 2) ? 1'b1 : 1'b0);
        end
        idle(4);
        chk("dup_violation", 64'(viol - v0), 64'(1));

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            drv(($urandom % 4) == 0, 30'($urandom), ($urandom % 3) == 0, ($urandom % 2) == 0,
                30'($urandom), $urandom, ($urandom % 3) == 0);
        end
        idle(20);
        chk("sb_drained", 64'(qi.size() + qd.size()), 64'(0));
        chk("model_drained", 64'({m_pv, m_fv}), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
